// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle RV32I controller and its datapath/memory.
// The master side is the controller: it consumes instruction fields and status
// flags and produces selects, strobes and the ALU operation code.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_WIDTH = 4
);
    // Instruction fields and datapath/memory status
    logic [6:0]                op;
    logic [2:0]                funct3;
    logic                      funct7b5;
    logic                      Zero;
    logic                      mem_ready;

    // Datapath controls and strobes
    logic                      mem_req;
    logic                      PCWrite;
    logic                      AdrSrc;
    logic                      MemWrite;
    logic                      IRWrite;
    logic                      RegWrite;
    logic [1:0]                ResultSrc;
    logic [1:0]                ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic [2:0]                ImmSrc;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    logic                      illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Main controller of the multicycle RV32I core. A state register sequences
// FETCH..WB; every control output is decoded from the current state and the
// live inputs so that handshake strobes (IRWrite, MemWrite, PCWrite) can react
// to mem_ready/Zero within the same cycle. Unsupported encodings park the
// machine in an absorbing ILLEGAL state until reset.
module multicycle_control_unit #(
    parameter int ALU_CTRL_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_control_unit_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
        S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD   = ALU_CTRL_WIDTH'(4'b0000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB   = ALU_CTRL_WIDTH'(4'b0001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND   = ALU_CTRL_WIDTH'(4'b0010);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR    = ALU_CTRL_WIDTH'(4'b0011);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_PASSB = ALU_CTRL_WIDTH'(4'b0100);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR   = ALU_CTRL_WIDTH'(4'b0101);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT   = ALU_CTRL_WIDTH'(4'b0110);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL   = ALU_CTRL_WIDTH'(4'b0111);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA   = ALU_CTRL_WIDTH'(4'b1000);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU  = ALU_CTRL_WIDTH'(4'b1001);
    localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL   = ALU_CTRL_WIDTH'(4'b1010);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RD1   = 2'b10;
    localparam logic [1:0] SRC_B_RD2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_DATA    = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    // Shared R/I arithmetic decode; only register ops honour funct7b5 for SUB,
    // while both honour it for the SRL/SRA choice.
    function automatic logic [ALU_CTRL_WIDTH-1:0] alu_decode(
        input logic [2:0] f3, input logic f7b5, input logic is_reg);
        logic [ALU_CTRL_WIDTH-1:0] code;
        case (f3)
            3'b000:  code = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    state_t                    state_q, state_d;
    logic                      mem_req_s, pc_write_s, adr_src_s, mem_write_s;
    logic                      ir_write_s, reg_write_s, illegal_s;
    logic [1:0]                result_src_s, alu_src_a_s, alu_src_b_s;
    logic [2:0]                imm_src_s;
    logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_s;

    // Next-state and control decode from current state and live inputs.
    always_comb begin
        state_d      = state_q;
        mem_req_s    = 1'b0;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_s    = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRC_A_PC;
        alu_src_b_s  = SRC_B_RD2;
        imm_src_s    = IMM_I;
        alu_ctrl_s   = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = SRC_B_FOUR;
                result_src_s = RES_ALURES;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
                else               state_d = S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm here for branch/jal targets.
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                case (bus.op)
                    OP_BRANCH: imm_src_s = IMM_B;
                    OP_JAL:    imm_src_s = IMM_J;
                    default:   imm_src_s = IMM_I;
                endcase
                case (bus.op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR1;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_s = SRC_A_RD1;
                alu_src_b_s = SRC_B_IMM;
                if (bus.op == OP_STORE) begin
                    imm_src_s = IMM_S;
                    state_d   = S_MEMWRITE;
                end else begin
                    imm_src_s = IMM_I;
                    state_d   = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
                else               state_d = S_MEMREAD;
            end
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
                else               state_d = S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a_s = SRC_A_RD1;
                alu_src_b_s = SRC_B_RD2;
                alu_ctrl_s  = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_s = SRC_A_RD1;
                alu_src_b_s = SRC_B_IMM;
                alu_ctrl_s  = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_s = SRC_A_RD1;
                alu_src_b_s = SRC_B_RD2;
                state_d     = S_FETCH;
                // Zero reflects the comparison: SUB==0 means equal, SLT(U)==0 means not less.
                case (bus.funct3)
                    3'b000:  begin alu_ctrl_s = ALU_SUB;  pc_write_s = bus.Zero;  end
                    3'b001:  begin alu_ctrl_s = ALU_SUB;  pc_write_s = ~bus.Zero; end
                    3'b100:  begin alu_ctrl_s = ALU_SLT;  pc_write_s = ~bus.Zero; end
                    3'b101:  begin alu_ctrl_s = ALU_SLT;  pc_write_s = bus.Zero;  end
                    3'b110:  begin alu_ctrl_s = ALU_SLTU; pc_write_s = ~bus.Zero; end
                    3'b111:  begin alu_ctrl_s = ALU_SLTU; pc_write_s = bus.Zero;  end
                    default: state_d = S_ILLEGAL;
                endcase
            end
            S_JAL: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_FOUR;
                pc_write_s  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_JALR1: begin
                alu_src_a_s = SRC_A_RD1;
                alu_src_b_s = SRC_B_IMM;
                state_d     = S_JALR2;
            end
            S_JALR2: begin
                // PC takes the target latched in ALUOut while OldPC+4 is formed for rd.
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_FOUR;
                pc_write_s  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b_s = SRC_B_IMM;
                imm_src_s   = IMM_U;
                alu_ctrl_s  = ALU_PASSB;
                state_d     = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a_s = SRC_A_OLDPC;
                alu_src_b_s = SRC_B_IMM;
                imm_src_s   = IMM_U;
                state_d     = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
                state_d   = S_ILLEGAL;
            end
            default: begin
                illegal_s = 1'b1;
                state_d   = S_ILLEGAL;
            end
        endcase
    end

    // State register; reset returns to FETCH immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Strobes and the illegal flag are held low for as long as reset is asserted.
    assign bus.mem_req    = mem_req_s   & ~rst;
    assign bus.PCWrite    = pc_write_s  & ~rst;
    assign bus.MemWrite   = mem_write_s & ~rst;
    assign bus.IRWrite    = ir_write_s  & ~rst;
    assign bus.RegWrite   = reg_write_s & ~rst;
    assign bus.illegal    = illegal_s   & ~rst;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ImmSrc     = imm_src_s;
    assign bus.ALUControl = alu_ctrl_s;
endmodule
